// File: rtl/core_mem_responder.sv
// Data-memory responder for the core: word RAM plus an MMIO window (GPIO, TX byte FIFO, cycle counter).
// Optional feature macro: MMIO_CYCLE_CNT_EN enables the cycle counter at MMIO offset 0x03.
module core_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [23:0] MMIO_TAG    = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ram_in_address,
  input  logic [31:0] ram_in_data,
  input  logic        ram_in_write,
  output logic [31:0] ram_out,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  localparam logic [7:0] OFS_GPIO_OUT = 8'h00;
  localparam logic [7:0] OFS_GPIO_IN  = 8'h01;
  localparam logic [7:0] OFS_TX       = 8'h02;
  localparam logic [7:0] OFS_CYCLE    = 8'h03;

  logic          is_mmio;
  logic [7:0]    offset;
  logic [AW-1:0] ram_idx;

  assign is_mmio = (ram_in_address[31:8] == MMIO_TAG);
  assign offset  = ram_in_address[7:0];
  assign ram_idx = ram_in_address[AW-1:0];

  // ---------------------------------------------------------------- RAM
  logic [31:0] ram [DEPTH_WORDS];

  // NOTE: storage arrays carry no reset branch so they map onto RAM macros; only the write is gated by reset.
  always_ff @(posedge clk) begin
    if (!rst_n && ram_in_write && !is_mmio) ram[ram_idx] <= ram_in_data;
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             empty, full, pop, push_req, push;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign pop      = !empty && tx_ready;
  assign push_req = ram_in_write && is_mmio && (offset == OFS_TX);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);

  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n && push) fifo_mem[wr_ptr] <= ram_in_data[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      gpio_out <= '0;
    end else begin
      if (ram_in_write && is_mmio && (offset == OFS_GPIO_OUT)) gpio_out <= ram_in_data;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- cycle counter
`ifdef MMIO_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst_n) cycle_cnt <= '0;
    else if (ram_in_write && is_mmio && (offset == OFS_CYCLE)) cycle_cnt <= '0;
    else cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

  // ---------------------------------------------------------------- read mux
  // NOTE: ram_out gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    ram_out = '0;
    if (is_mmio) begin
      case (offset)
        OFS_GPIO_OUT: ram_out = gpio_out;
        OFS_GPIO_IN:  ram_out = gpio_in;
        OFS_TX:       ram_out = {29'b0, overflow, full, empty};
`ifdef MMIO_CYCLE_CNT_EN
        OFS_CYCLE:    ram_out = cycle_cnt;
`endif
        default:      ram_out = '0;
      endcase
    end else begin
      ram_out = ram[ram_idx];
    end
  end

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed self-checking bench for core_mem_responder (default parameters).
module tb_core_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ram_in_address;
  logic [31:0] ram_in_data;
  logic        ram_in_write;
  logic [31:0] ram_out;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] A_GPIO_OUT = 32'hFFFFFF00;
  localparam logic [31:0] A_GPIO_IN  = 32'hFFFFFF01;
  localparam logic [31:0] A_TX       = 32'hFFFFFF02;
  localparam logic [31:0] A_CYCLE    = 32'hFFFFFF03;

  core_mem_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ram_in_address (ram_in_address),
    .ram_in_data    (ram_in_data),
    .ram_in_write   (ram_in_write),
    .ram_out        (ram_out),
    .gpio_in        (gpio_in),
    .gpio_out       (gpio_out),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    ram_in_address = addr;
    ram_in_data    = data;
    ram_in_write   = 1'b1;
    tick();
    ram_in_write   = 1'b0;
    #1;
  endtask

  logic [7:0] exp_seq [8];

  initial begin
    rst_n          = 1'b1;
    ram_in_address = '0;
    ram_in_data    = '0;
    ram_in_write   = 1'b0;
    gpio_in        = '0;
    tx_ready       = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;

    // Reset state
    ram_in_address = A_TX;
    #1;
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_status", ram_out, 32'h1);

    // RAM write / read / alias / read-during-write
    wr(32'd5, 32'hDEADBEEF);
    ram_in_address = 32'd5;
    #1;
    check("ram_read", ram_out, 32'hDEADBEEF);
    ram_in_address = 32'd5 + 32'd256;
    #1;
    check("ram_alias", ram_out, 32'hDEADBEEF);
    ram_in_address = 32'd5;
    ram_in_data    = 32'h1;
    ram_in_write   = 1'b1;
    #1;
    check("ram_rdw_old", ram_out, 32'hDEADBEEF);
    tick();
    ram_in_write = 1'b0;
    #1;
    check("ram_rdw_new", ram_out, 32'h1);

    // GPIO
    wr(A_GPIO_OUT, 32'hA5A50F0F);
    check("gpio_out_wr", gpio_out, 32'hA5A50F0F);
    ram_in_address = A_GPIO_OUT;
    #1;
    check("gpio_out_rd", ram_out, 32'hA5A50F0F);
    gpio_in        = 32'h12345678;
    ram_in_address = A_GPIO_IN;
    #1;
    check("gpio_in_rd", ram_out, 32'h12345678);
    wr(32'hFFFFFF10, 32'h0BADF00D);
    check("unmapped_rd", ram_out, 32'h0);
    check("unmapped_wr_ignored", gpio_out, 32'hA5A50F0F);

    // FIFO fill and overflow with tx_ready low
    ram_in_address = A_TX;
    ram_in_data    = 32'h01;
    ram_in_write   = 1'b1;
    #1;
    check("no_bypass_valid", {31'b0, tx_valid}, 32'h0);
    tick();
    ram_in_write = 1'b0;
    #1;
    check("first_push_valid", {31'b0, tx_valid}, 32'h1);
    check("first_push_data", {24'b0, tx_data}, 32'h01);
    for (int i = 2; i <= 9; i++) wr(A_TX, 32'(i));
    check("status_full_ovf", ram_out, 32'h6);

    // Drain
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      check($sformatf("drain_data_%0d", i), {24'b0, tx_data}, 32'(i));
      check($sformatf("drain_valid_%0d", i), {31'b0, tx_valid}, 32'h1);
      tick();
    end
    #1;
    check("drained_valid", {31'b0, tx_valid}, 32'h0);
    check("drained_status", ram_out, 32'h5);
    tx_ready = 1'b0;

    // Simultaneous push and pop on a full FIFO
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h10 + 32'(i));
    check("refill_status", ram_out, 32'h6);
    tx_ready       = 1'b1;
    ram_in_data    = 32'h55;
    ram_in_write   = 1'b1;
    #1;
    check("pp_head_before", {24'b0, tx_data}, 32'h10);
    tick();
    ram_in_write = 1'b0;
    #1;
    check("pp_still_full", ram_out, 32'h6);
    exp_seq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
    for (int k = 0; k < 8; k++) begin
      check($sformatf("pp_seq_%0d", k), {24'b0, tx_data}, {24'b0, exp_seq[k]});
      tick();
    end
    #1;
    check("pp_empty_valid", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Reset mid-drain; a GPIO write during reset is ignored
    wr(A_TX, 32'hA1);
    wr(A_TX, 32'hA2);
    wr(A_TX, 32'hA3);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    tick();
    tx_ready       = 1'b1;
    rst_n          = 1'b1;
    ram_in_address = A_GPIO_OUT;
    ram_in_data    = 32'h0000FFFF;
    ram_in_write   = 1'b1;
    tick();
    rst_n          = 1'b0;
    ram_in_write   = 1'b0;
    tx_ready       = 1'b0;
    ram_in_address = A_TX;
    #1;
    check("midrst_valid", {31'b0, tx_valid}, 32'h0);
    check("midrst_status", ram_out, 32'h1);
    check("midrst_gpio", gpio_out, 32'h0);

    // RAM write during reset is ignored
    wr(32'd7, 32'h77);
    rst_n          = 1'b1;
    ram_in_address = 32'd7;
    ram_in_data    = 32'h99;
    ram_in_write   = 1'b1;
    tick();
    rst_n        = 1'b0;
    ram_in_write = 1'b0;
    #1;
    check("rst_ram_wr_ignored", ram_out, 32'h77);

    // Cycle counter: 10 edges after the reset edge
    ram_in_address = A_CYCLE;
    repeat (10) tick();
`ifdef MMIO_CYCLE_CNT_EN
    check("cycle_10", ram_out, 32'd10);
    wr(A_CYCLE, 32'h1234);
    check("cycle_clear", ram_out, 32'h0);
    dut.cycle_cnt = 32'hFFFFFFFF;
    #1;
    check("cycle_max", ram_out, 32'hFFFFFFFF);
    tick();
    check("cycle_wrap", ram_out, 32'h0);
`else
    check("cycle_absent", ram_out, 32'h0);
    wr(A_CYCLE, 32'h1234);
    check("cycle_absent_wr", ram_out, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_mem_responder.md
Name: core_mem_responder

Overview:
- Responder end of the core's data-memory port: services the word address, write data and write strobe driven by the core's MEM stage, and returns read data on the same cycle.
- Contains a word-addressed data RAM plus a small MMIO window: GPIO out/in, a byte TX FIFO with valid/ready drain, and a free-running cycle counter.
- Sits beside the core at top level, wired directly to its RAM_IN_ADDRESS / RAM_IN_DATA / RAM_IN_WRITE / RAM_OUT pins.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit RAM words; power of two, min 4.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, min 2.
- MMIO_TAG, 24'hFFFFFF, value of addr[31:8] that selects the MMIO window.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-high (1 = reset).
- ram_in_address  in  32  word address from the core's MEM stage.
- ram_in_data  in  32  write data.
- ram_in_write  in  1  write strobe, sampled at rising edge.
- ram_out  out  32  read data, combinational from ram_in_address.
- gpio_in  in  32  external input, read through MMIO.
- gpio_out  out  32  GPIO output register.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  downstream accepts the head byte.

Behaviour:
- Decode:
  - addr[31:8]==MMIO_TAG selects MMIO, offset = addr[7:0].
  - Otherwise RAM, index = addr[log2(DEPTH_WORDS)-1:0]; upper bits are ignored and the RAM aliases.
- RAM:
  - Write occurs at the rising edge when ram_in_write=1.
  - Read is asynchronous, so the core captures it at the same edge.
  - Read and write to the same word in the same cycle: ram_out shows the old value.
  - RAM contents are not reset.
- MMIO map (writes at rising edge when ram_in_write=1):
  - 0x00 GPIO_OUT: RW; full 32-bit write.
  - 0x01 GPIO_IN: RO; returns gpio_in unregistered.
  - 0x02 TX: a write pushes ram_in_data[7:0]. A read returns {29'b0, overflow, full, empty}.
  - 0x03 CYCLE: RO count. A write clears it (next value 0; clear wins over increment).
  - Any other offset reads 0; writes to it are ignored.
- TX FIFO:
  - tx_valid = !empty; tx_data = head.
  - Pop occurs when tx_valid and tx_ready are both 1 at the edge.
  - Push is accepted if count<FIFO_DEPTH or a pop occurs in the same cycle. Push and pop together on a full FIFO leaves count unchanged.
  - A push to an empty FIFO raises tx_valid the cycle after the write edge; there is no same-cycle bypass.
  - A push while full with no pop is dropped and sets a sticky overflow bit, cleared only by reset.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Cycle counter: increments every non-reset cycle; wraps 32'hFFFFFFFF->0.
- Reset (rst_n=1 at edge):
  - gpio_out=0, FIFO empty, tx_valid=0, overflow=0, counter=0.
  - Reset mid-drain discards FIFO contents; tx_ready is ignored during reset.
  - Writes during reset are ignored, including RAM writes.
- No read side effects: ram_out is a pure function of address and state.

Optional Feature:
- MMIO_CYCLE_CNT_EN defined: cycle counter present at offset 0x03 as above.
- Undefined: counter logic is removed, offset 0x03 reads 0, and writes to it are ignored.

Test Plan:
- RAM: write 0xDEADBEEF to addr 5, then read addr 5 -> ram_out=0xDEADBEEF. Read addr 5+DEPTH_WORDS -> same value (alias). Write 0x1 to addr 5 while reading addr 5 -> ram_out=0xDEADBEEF that cycle, 0x1 next cycle.
- GPIO: write 0xA5A5_0F0F to 0xFFFFFF00 -> gpio_out=0xA5A50F0F after the edge. Drive gpio_in=0x12345678 and read 0xFFFFFF01 -> ram_out=0x12345678. Reset -> gpio_out=0.
- FIFO fill/overflow with tx_ready=0: write bytes 0x01..0x09 to 0xFFFFFF02 -> status reads 0b110 (overflow, full). Raise tx_ready -> tx_data sequence 0x01..0x08, then tx_valid=0 and status=0b101.
- Simultaneous push/pop: with the FIFO full and tx_ready=1, write 0x55 -> count stays 8, head advances, and 0x55 emerges last.
- Cycle counter (macro defined): 10 idle cycles after reset -> 0xFFFFFF03 reads 10. Write any value -> reads 0 the next cycle. Force the count to 32'hFFFFFFFF via a hierarchical deposit -> next read 0. With the macro undefined, offset 0x03 reads 0.
- Reset mid-drain: 3 bytes queued, tx_ready toggling, assert rst_n for 1 cycle -> tx_valid=0 and status=0b001 the cycle after.
